stream_demux_n: RTL and testbench

Parametrised 1-to-N stream de-multiplexer with valid/ready handshaking, packet-aware routing and one registered output stage per channel. It generalises the combinational 1-to-2 and 1-to-4 demuxes to any channel count and data width. Channel select is latched for a whole packet, and unroutable packets are discarded and counted. It sits between a single packet source and N downstream consumers.

---
 rtl/stream_demux_n.sv | 171 +++++++++++++++++
 tb/tb_stream_demux_n.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_n.sv
// -----------------------------------------------------------------------------
// stream_demux_n
//   1-to-N valid/ready stream de-multiplexer with packet-aware routing.
//   The destination is taken from in_sel on the first beat of a packet and held
//   until in_last (PKT_MODE=1), or taken on every beat (PKT_MODE=0). Packets
//   addressed to a non-existent channel are swallowed and counted. Each output
//   channel has one register stage, which supports a drain and a reload in the
//   same cycle so that it can accept one beat per clock.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_data    input beat
//   in_valid   input beat valid
//   in_last    final beat of packet
//   in_sel     destination channel
//   in_ready   input accepted when in_valid & in_ready
//   out_data   channel k occupies bits [k*DATA_W +: DATA_W]
//   out_valid  per-channel valid
//   out_last   per-channel last flag
//   out_ready  per-channel ready
//   busy       high while inside a packet (BUSY or DROP)
//   drop_cnt   dropped-packet count, saturating
//
// State table
//   state  | meaning
//   IDLE   | waiting for the first beat; target follows in_sel
//   BUSY   | mid-packet; target is the latched channel
//   DROP   | mid-packet for an unroutable destination; beats are discarded
// -----------------------------------------------------------------------------
module stream_demux_n #(
    parameter int DATA_W   = 8,
    parameter int N_OUT    = 4,
    parameter int PKT_MODE = 1,
    parameter int CNT_W    = 8,
    localparam int SEL_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    in_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    output logic [N_OUT-1:0]        out_last,
    input  logic [N_OUT-1:0]        out_ready,
    output logic                    busy,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [SEL_W-1:0]        chan_q, chan_d;
    logic [CNT_W-1:0]        drop_q, drop_d;
    logic [N_OUT*DATA_W-1:0] data_q;
    logic [N_OUT-1:0]        valid_q;
    logic [N_OUT-1:0]        last_q;

    logic             sel_ok;
    logic [SEL_W-1:0] target;
    logic             full;
    logic             accept;
    logic             route;
    logic [N_OUT-1:0] load;

    // Codes N_OUT..2^SEL_W-1 exist only when N_OUT is not a power of two.
    assign sel_ok = (32'(in_sel) < 32'(N_OUT));
    assign target = (state_q == S_BUSY) ? chan_q : in_sel;

    always_comb begin
        full = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (target == SEL_W'(k)) begin
                full = valid_q[k] & ~out_ready[k];
            end
        end
    end

    always_comb begin
        case (state_q)
            S_DROP:  in_ready = 1'b1;
            S_BUSY:  in_ready = ~full;
            default: in_ready = sel_ok ? ~full : 1'b1;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign route  = accept & ((state_q == S_BUSY) | ((state_q == S_IDLE) & sel_ok));

    always_comb begin
        load = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (target == SEL_W'(k)) begin
                load[k] = route;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        drop_d  = drop_q;
        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (sel_ok) begin
                        if (!in_last && PKT_MODE != 0) begin
                            state_d = S_BUSY;
                            chan_d  = in_sel;
                        end
                    end else begin
                        // Counted once, on the first beat of the packet.
                        if (drop_q != '1) begin
                            drop_d = drop_q + 1'b1;
                        end
                        if (!in_last && PKT_MODE != 0) begin
                            state_d = S_DROP;
                        end
                    end
                end
                S_BUSY:  if (in_last) state_d = S_IDLE;
                S_DROP:  if (in_last) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            chan_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            drop_q  <= drop_d;
        end
    end

    // A load takes priority over a drain so that a register emptied this
    // cycle can be refilled in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (load[k]) begin
                    data_q[k*DATA_W +: DATA_W] <= in_data;
                    last_q[k]                  <= in_last;
                    valid_q[k]                 <= 1'b1;
                end else if (out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = (state_q != S_IDLE);
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_stream_demux_n.sv
module tb_stream_demux_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic [1:0]  in_sel;
    logic        use_b;

    // DUT A: 4 channels, packet mode, 8-bit counter
    logic        a_in_valid, a_in_ready, a_busy;
    logic [31:0] a_out_data;
    logic [3:0]  a_out_valid, a_out_last, a_out_ready;
    logic [7:0]  a_drop;

    // DUT B: 3 channels (code 3 unroutable), 2-bit counter
    logic        b_in_valid, b_in_ready, b_busy;
    logic [23:0] b_out_data;
    logic [2:0]  b_out_valid, b_out_last, b_out_ready;
    logic [1:0]  b_drop;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] qa[4][$];
    logic [8:0] qb[3][$];

    always #5 clk = ~clk;

    assign a_in_valid = in_valid & ~use_b;
    assign b_in_valid = in_valid & use_b;

    stream_demux_n #(.DATA_W(8), .N_OUT(4), .PKT_MODE(1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(a_in_valid), .in_last(in_last), .in_sel(in_sel),
        .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last),
        .out_ready(a_out_ready),
        .busy(a_busy), .drop_cnt(a_drop)
    );

    stream_demux_n #(.DATA_W(8), .N_OUT(3), .PKT_MODE(1), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(b_in_valid), .in_last(in_last), .in_sel(in_sel),
        .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last),
        .out_ready(b_out_ready),
        .busy(b_busy), .drop_cnt(b_drop)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard pops on the falling edge, then advance to just after the next
    // rising edge. out_ready only changes right after a rising edge.
    task automatic tick();
        logic [8:0] e;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (a_out_valid[k] && a_out_ready[k]) begin
                if (qa[k].size() == 0) chk($sformatf("a_unexpected_ch%0d", k), {23'd0, a_out_last[k], a_out_data[k*8 +: 8]}, 32'hFFFF);
                else begin
                    e = qa[k].pop_front();
                    chk($sformatf("a_ch%0d_beat", k), {23'd0, a_out_last[k], a_out_data[k*8 +: 8]}, {23'd0, e});
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (b_out_valid[k] && b_out_ready[k]) begin
                if (qb[k].size() == 0) chk($sformatf("b_unexpected_ch%0d", k), {23'd0, b_out_last[k], b_out_data[k*8 +: 8]}, 32'hFFFF);
                else begin
                    e = qb[k].pop_front();
                    chk($sformatf("b_ch%0d_beat", k), {23'd0, b_out_last[k], b_out_data[k*8 +: 8]}, {23'd0, e});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for in_ready, record the expectation.
    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic l, input int exp_ch);
        int w;
        in_data  = d;
        in_sel   = s;
        in_last  = l;
        in_valid = 1'b1;
        #1;
        w = 0;
        while (!(use_b ? b_in_ready : a_in_ready) && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) chk("ready_timeout", w, 0);
        if (exp_ch >= 0) begin
            if (use_b) qb[exp_ch].push_back({l, d});
            else       qa[exp_ch].push_back({l, d});
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        use_b       = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_sel      = '0;
        a_out_ready = 4'hF;
        b_out_ready = 3'h7;
        #23;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_drop_cnt", a_drop, 0);
        rst = 1'b0;
        tick();

        // single-beat packets to every channel
        for (int i = 0; i < 4; i++) begin
            send(8'h10 + 8'(i), 2'(i), 1'b1, i);
            chk("single_busy", a_busy, 0);
        end

        // 4-beat packet to ch2, in_sel changes mid-packet
        send(8'hA0, 2'd2, 1'b0, 2);
        chk("pkt_busy_b1", a_busy, 1);
        send(8'hA1, 2'd1, 1'b0, 2);
        send(8'hA2, 2'd1, 1'b0, 2);
        chk("pkt_busy_b3", a_busy, 1);
        send(8'hA3, 2'd1, 1'b1, 2);
        chk("pkt_busy_end", a_busy, 0);

        // back-pressure on ch1 while ch0 drains
        a_out_ready = 4'b1100;
        send(8'h01, 2'd0, 1'b1, 0);
        send(8'h11, 2'd1, 1'b1, 1);
        in_data = 8'h12; in_sel = 2'd1; in_last = 1'b1; in_valid = 1'b1;
        #1;
        chk("bp_in_ready", a_in_ready, 0);
        chk("bp_hold_data", a_out_data[15:8], 8'h11);
        chk("bp_hold_valid", a_out_valid[1], 1);
        a_out_ready = 4'b1101;
        tick();
        chk("bp_ch0_drained", a_out_valid[0], 0);
        chk("bp_still_held", a_out_data[15:8], 8'h11);
        chk("bp_still_stalled", a_in_ready, 0);
        a_out_ready = 4'hF;
        send(8'h12, 2'd1, 1'b1, 1);
        send(8'h13, 2'd1, 1'b1, 1);

        // reset in the middle of a packet
        send(8'hB0, 2'd1, 1'b0, 1);
        send(8'hB1, 2'd1, 1'b0, 1);
        chk("mid_busy", a_busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_busy", a_busy, 0);
        for (int k = 0; k < 4; k++) qa[k].delete();
        tick();
        rst = 1'b0;
        send(8'hB2, 2'd3, 1'b0, 3);
        send(8'hB3, 2'd3, 1'b1, 3);
        tick();
        tick();

        // unroutable packet on the 3-channel instance
        use_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hC0 + 8'(i); in_sel = 2'd3; in_last = (i == 2); in_valid = 1'b1;
            #1;
            chk("drop_in_ready", b_in_ready, 1);
            send(8'hC0 + 8'(i), 2'd3, (i == 2), -1);
            chk("drop_cnt_pkt", b_drop, 1);
            chk("drop_busy", b_busy, (i == 2) ? 0 : 1);
        end
        chk("drop_no_valid", b_out_valid, 0);
        send(8'h55, 2'd0, 1'b1, 0);

        // saturation of the 2-bit drop counter
        for (int i = 0; i < 4; i++) begin
            send(8'hD0 + 8'(i), 2'd3, 1'b1, -1);
            chk("drop_sat", b_drop, (i == 0) ? 2 : 3);
        end

        for (int i = 0; i < 3; i++) tick();
        for (int k = 0; k < 4; k++) chk($sformatf("a_q%0d_left", k), qa[k].size(), 0);
        for (int k = 0; k < 3; k++) chk($sformatf("b_q%0d_left", k), qb[k].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
